// File: rtl/arm_regfile_pkg.sv
// arm_regfile shared constants.
// Widths, PC index and PC sequencing values.
package arm_regfile_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int IDX_W       = 4;
    localparam int NUM_REGS    = 16;
    localparam int PC_IDX      = 15;
    localparam int PC_INC      = 4;
    localparam int PC_READ_OFS = 8;

    localparam logic [DATA_WIDTH-1:0] RESET_PC = '0;

endpackage

// File: rtl/arm_regfile_reg_decoder.sv
// One-hot write-address decoder.
// Bit 15 selects the PC, bits 0-14 the GPRs.
module reg_decoder
    import arm_regfile_pkg::*;
#(
    parameter int N = NUM_REGS
) (
    input  logic                 we3,
    input  logic [$clog2(N)-1:0] wa3,
    output logic [N-1:0]         wen
);

    // one-hot select, all zero when no write
    always_comb begin
        wen = '0;
        if (we3) begin
            wen = N'(1) << wa3;
        end
    end

endmodule

// File: rtl/arm_regfile.sv
// Architectural register file with PC.
// Two combinational reads, one clocked write.
module arm_regfile
    import arm_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = arm_regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGS    = arm_regfile_pkg::NUM_REGS,
    parameter int PC_INC      = arm_regfile_pkg::PC_INC,
    parameter int PC_READ_OFS = arm_regfile_pkg::PC_READ_OFS,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            ra1,
    input  logic [3:0]            ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic [3:0]            wa3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic                  we3,
    input  logic                  pc_stall,
    output logic [DATA_WIDTH-1:0] pc_out
);

    localparam logic [3:0] PCA = 4'(PC_IDX);

    logic [NUM_REGS-1:0]   wen;
    logic                  wr_act;
    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-2];
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_rd;

    // a reset cycle never writes, so it never bypasses either
    assign wr_act = we3 & ~reset;

    reg_decoder #(.N(NUM_REGS)) u_dec (
        .we3 (wr_act),
        .wa3 (wa3),
        .wen (wen)
    );

    // general purpose registers with per-register enables
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (wen[i]) begin
                regs[i] <= wd3;
            end
        end
    end

    // PC: reset, then branch load, then stall, then increment
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (wen[PC_IDX]) begin
            pc <= {wd3[DATA_WIDTH-1:2], 2'b00};
        end else if (!pc_stall) begin
            pc <= pc + DATA_WIDTH'(PC_INC);
        end
    end

    assign pc_out = pc;
    assign pc_rd  = pc + DATA_WIDTH'(PC_READ_OFS);

    // read port 1: r15 returns PC+offset, GPRs may bypass
    always_comb begin
        rd1 = '0;
        if (ra1 == PCA) begin
            rd1 = pc_rd;
        end else if (BYPASS && wr_act && (wa3 == ra1)) begin
            rd1 = wd3;
        end else begin
            rd1 = regs[ra1];
        end
    end

    // read port 2: identical to port 1
    always_comb begin
        rd2 = '0;
        if (ra2 == PCA) begin
            rd2 = pc_rd;
        end else if (BYPASS && wr_act && (wa3 == ra2)) begin
            rd2 = wd3;
        end else begin
            rd2 = regs[ra2];
        end
    end

endmodule

// File: tb/tb_arm_regfile.sv
// Directed bench for arm_regfile.
// Expected values are queued when driven, popped at check.
module tb_arm_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1, ra2, wa3;
    logic [31:0] wd3;
    logic        we3, pc_stall;
    logic [31:0] rd1, rd2, pc_out;
    logic [31:0] nb_rd1, nb_rd2, nb_pc;

    typedef enum logic [1:0] {O_RD1, O_RD2, O_PC, O_NB1} osel_t;
    typedef struct {
        string       tag;
        osel_t       sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    arm_regfile #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2),
        .wa3(wa3), .wd3(wd3), .we3(we3),
        .pc_stall(pc_stall), .pc_out(pc_out)
    );

    arm_regfile #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2),
        .rd1(nb_rd1), .rd2(nb_rd2),
        .wa3(wa3), .wd3(wd3), .we3(we3),
        .pc_stall(pc_stall), .pc_out(nb_pc)
    );

    task automatic expect_v(input string tag, input osel_t s,
                            input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                O_RD1:   obs = rd1;
                O_RD2:   obs = rd2;
                O_PC:    obs = pc_out;
                default: obs = nb_rd1;
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        we3      = 1'b1;
        wa3      = 4'd3;
        wd3      = 32'hDEADBEEF;
        pc_stall = 1'b0;
        ra1      = 4'd3;
        ra2      = 4'd15;
        tick();
        tick();

        // reset held with a pending write
        expect_v("rst_pc", O_PC, 32'h0);
        expect_v("rst_r3", O_RD1, 32'h0);
        expect_v("rst_r15", O_RD2, 32'h8);
        check_all();
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i);
            expect_v($sformatf("rst_r%0d", i), O_RD1, 32'h0);
            check_all();
        end

        // release, write r3 then r14, PC counts
        reset = 1'b0;
        we3   = 1'b1;
        wa3   = 4'd3;
        wd3   = 32'hAAAAAAAA;
        expect_v("pc0", O_PC, 32'h0);
        check_all();
        tick();
        wa3 = 4'd14;
        wd3 = 32'h12345678;
        expect_v("pc4", O_PC, 32'h4);
        check_all();
        tick();
        we3 = 1'b0;
        expect_v("pc8", O_PC, 32'h8);
        check_all();
        tick();
        expect_v("pcC", O_PC, 32'hC);
        ra1 = 4'd3;
        ra2 = 4'd14;
        expect_v("rb_r3", O_RD1, 32'hAAAAAAAA);
        expect_v("rb_r14", O_RD2, 32'h12345678);
        check_all();
        ra2 = 4'd3;
        expect_v("dual_p1", O_RD1, 32'hAAAAAAAA);
        expect_v("dual_p2", O_RD2, 32'hAAAAAAAA);
        check_all();

        // stall two cycles
        pc_stall = 1'b1;
        tick();
        expect_v("stall1", O_PC, 32'hC);
        check_all();
        tick();
        ra1 = 4'd15;
        expect_v("stall2", O_PC, 32'hC);
        expect_v("r15_rd", O_RD1, 32'h14);
        check_all();

        // same-cycle bypass vs. no bypass
        we3 = 1'b1;
        wa3 = 4'd5;
        wd3 = 32'h55;
        ra1 = 4'd5;
        expect_v("byp_on", O_RD1, 32'h55);
        expect_v("byp_off", O_NB1, 32'h0);
        check_all();
        tick();
        we3 = 1'b0;
        expect_v("wr_r5", O_RD1, 32'h55);
        expect_v("wr_r5_nb", O_NB1, 32'h55);
        expect_v("stall3", O_PC, 32'hC);
        check_all();

        // branch via r15 write, stall ignored, no r15 bypass
        we3 = 1'b1;
        wa3 = 4'd15;
        wd3 = 32'h00001003;
        ra2 = 4'd15;
        expect_v("r15_nobyp", O_RD2, 32'h14);
        check_all();
        tick();
        we3 = 1'b0;
        expect_v("branch", O_PC, 32'h00001000);
        expect_v("br_r15", O_RD2, 32'h00001008);
        check_all();

        // wrap-around
        we3 = 1'b1;
        wa3 = 4'd15;
        wd3 = 32'hFFFFFFFF;
        tick();
        we3      = 1'b0;
        pc_stall = 1'b0;
        ra1      = 4'd15;
        expect_v("wrap_ld", O_PC, 32'hFFFFFFFC);
        expect_v("wrap_r15", O_RD1, 32'h4);
        check_all();
        tick();
        expect_v("wrap_pc", O_PC, 32'h0);
        expect_v("wrap_r15b", O_RD1, 32'h8);
        check_all();
        tick();
        expect_v("pc_after", O_PC, 32'h4);
        check_all();

        // reset mid-operation beats write and stall
        reset    = 1'b1;
        we3      = 1'b1;
        wa3      = 4'd5;
        wd3      = 32'h99;
        pc_stall = 1'b1;
        ra1      = 4'd5;
        expect_v("rst_nobyp", O_RD1, 32'h55);
        check_all();
        tick();
        reset = 1'b0;
        we3   = 1'b0;
        expect_v("rst2_pc", O_PC, 32'h0);
        expect_v("rst2_r5", O_RD1, 32'h0);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_regfile.md
# arm_regfile

Architectural register file for the single-cycle ARM datapath: sixteen 32-bit registers (r0–r14 general purpose, r15 program counter) with two combinational read ports and one clocked write port. Sits between instruction decode (read addresses) and write-back (write data). Owns PC sequencing: r15 advances by 4 every cycle unless stalled or explicitly written by a branch or PC-destination instruction.

## Interface
- `DATA_WIDTH`, 32, register width in bits.
- `NUM_REGS`, 16, register count; fixed at 16 for ARM; address width is log2 of this (4).
- `PC_INC`, 4, PC increment per non-stalled cycle.
- `PC_READ_OFS`, 8, offset added to the PC when r15 is read through a read port.
- `BYPASS`, 1, when 1, a read of the register being written this cycle returns the write data.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `ra1`  in  4  read address, port 1.
- `ra2`  in  4  read address, port 2.
- `rd1`  out  32  read data, port 1, combinational.
- `rd2`  out  32  read data, port 2, combinational.
- `wa3`  in  4  write address.
- `wd3`  in  32  write data.
- `we3`  in  1  write enable.
- `pc_stall`  in  1  holds the PC when no write targets r15.
- `pc_out`  out  32  current PC, registered; drives instruction fetch.

## Operation
- **Storage:** r0–r14 are 32-bit registers with individual enables. r15 is the PC register.
- **Write to r0–r14:** with `we3`=1 and `wa3`<15, register `wa3` loads `wd3` at the edge. All other registers hold.
- **PC update, per edge, in priority order:**
  1. `reset` → PC=0.
  2. `we3`=1 and `wa3`=15 → PC = `wd3` with bits [1:0] cleared (word-aligned).
  3. `pc_stall`=1 → PC holds.
  4. Otherwise → PC = PC + `PC_INC`, modulo 2^32.
- **Read, r0–r14:** `rdN` = register[`raN`].
  - With `BYPASS`=1, `we3`=1 and `wa3`=`raN`<15: `rdN` = `wd3`.
- **Read, r15:** `rdN` = PC + `PC_READ_OFS` (mod 2^32), using the current PC. r15 is never bypassed.
- **Same address on both ports:** both ports return identical data.
- **Wrap-around:** PC 0xFFFFFFFC + 4 → 0x00000000. Reading r15 at PC 0xFFFFFFFC returns 0x00000004.
- **No write:** `we3`=0 changes no register except the PC, which follows its own increment/stall rule.

## Timing
- **Reset:**
  - Reset value of all r0–r14 = 0. PC = 0. `pc_out` = 0 in the cycle after `reset` is sampled.
  - With `reset` held, `rd1`/`rd2` = 0 for r0–r14 and 8 for r15.
- **Reset mid-operation:** `reset` wins over a simultaneous write and over `pc_stall`. No write occurs in a reset cycle.
- **Write latency:** 1 cycle. Data written at edge N is visible on the read ports in cycle N+1 (same cycle if bypassed).
- **PC latency:** `pc_out` updates at the edge. A branch written at edge N is fetched in cycle N+1.
- **Read ports:** purely combinational from `raN`, the register array, the PC and the bypass inputs. No added cycles.
- **Stall with r15 write:** the write takes effect; `pc_stall` is ignored.

## Structure
- **Shared package:** `DATA_WIDTH`, register-index width (4), `PC_IDX`=15, `PC_INC`, `PC_READ_OFS`, reset PC constant.
- **Sub-module `reg_decoder`:** 4-to-16 one-hot write decode gated by `we3`. Output bit 15 feeds the PC load path; bits 0–14 feed the per-register enables.
- **Top level:** the register array, the PC next-state logic, and two identical read muxes (r15 offset and bypass included).

## Test plan
- **Reset:** assert `reset` 2 cycles with `we3`=1, `wa3`=3, `wd3`=0xDEADBEEF → `pc_out`=0; all r0–r14 read 0; r15 reads 8.
- **Write/read back:** write r3=0xAAAAAAAA, r14=0x12345678 on consecutive cycles → `ra1`=3, `ra2`=14 give 0xAAAAAAAA / 0x12345678. Dual reads of r3 on both ports match.
- **Bypass:** `we3`=1, `wa3`=5, `wd3`=0x55, `ra1`=5 in the same cycle → `rd1`=0x55 before the edge. With `BYPASS`=0 → `rd1` shows the old value.
- **PC sequencing:** release reset, `pc_stall`=0 for 3 cycles → `pc_out` 0, 4, 8, 0xC. `pc_stall`=1 for 2 cycles → holds 0xC. r15 read → 0x14.
- **Branch via r15 write:** `we3`=1, `wa3`=15, `wd3`=0x00001003, `pc_stall`=1 → next `pc_out`=0x00001000.
- **Wrap:** load PC=0xFFFFFFFC via r15 write, then one free cycle → `pc_out`=0. r15 read before the edge = 0x00000004.
